// File: rtl/alu_seg_pkg.sv
// Shared constants for the ALU seven-segment board top: segment encodings,
// anode one-hot patterns and the digit-index enumeration.
package alu_seg_pkg;

    // Active-low segment patterns, bit order GFEDCBA.
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;
    // Shown when the decoder input is not a clean 0..F value ("U").
    localparam logic [6:0] SEG_U = 7'b1000001;

    // Active-low one-hot anodes; an[0] is the rightmost digit.
    localparam logic [3:0] AN_D0 = 4'b1110;
    localparam logic [3:0] AN_D1 = 4'b1101;
    localparam logic [3:0] AN_D2 = 4'b1011;
    localparam logic [3:0] AN_D3 = 4'b0111;

    // Digit index, right to left: A, B, A+B, A-B.
    typedef enum logic [1:0] {
        DIG_A    = 2'd0,
        DIG_B    = 2'd1,
        DIG_SUM  = 2'd2,
        DIG_DIFF = 2'd3
    } digit_e;

endpackage

// File: rtl/alu_seg_hex_to_seg7.sv
// Hex nibble to active-low seven-segment pattern (GFEDCBA). Purely combinational.
module hex_to_seg7
    import alu_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Table lookup; the default catches X/Z in simulation and shows "U".
    always_comb begin
        seg = SEG_U;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_U;
        endcase
    end

endmodule

// File: rtl/alu_seg_top.sv
// Board top: 4-bit ALU on slide switches, shown as A, B, A+B, A-B on a
// time-multiplexed 4-digit seven-segment display. The scan timebase is a
// clock enable derived from the single board clock; no generated clocks.
module alu_seg_top
    import alu_seg_pkg::*;
#(
    parameter int DIVIDE_BY = 1   // clk edges per half-period of the scan timebase, >= 1
) (
    input  logic       clk,
    input  logic       btnC,
    input  logic [7:0] sw,
    output logic [3:0] an,
    output logic [6:0] seg
);

    // A one-bit counter is still needed when DIVIDE_BY is 1 ($clog2(1) is 0).
    localparam int CW = (DIVIDE_BY > 1) ? $clog2(DIVIDE_BY) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIVIDE_BY - 1);

    // Declaration values give the FPGA power-up state, identical to reset.
    logic [CW-1:0] cnt = '0;
    logic          tb  = 1'b0;
    digit_e        d   = DIG_A;

    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic [3:0] diff;
    logic [3:0] value;

    // Divider, timebase toggle and digit index; the digit steps when tb rises.
    always_ff @(posedge clk) begin
        if (btnC) begin
            cnt <= '0;
            tb  <= 1'b0;
            d   <= DIG_A;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            tb  <= ~tb;
            if (!tb) begin
                d <= digit_e'(d + 2'd1);
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // 4-bit wrap-around arithmetic; carry and borrow are deliberately dropped.
    assign a    = sw[3:0];
    assign b    = sw[7:4];
    assign sum  = a + b;
    assign diff = a - b;

    // Digit mux and anode decode, straight from d and the switches (no register stage).
    always_comb begin
        value = a;
        an    = AN_D0;
        case (d)
            DIG_A:    begin value = a;    an = AN_D0; end
            DIG_B:    begin value = b;    an = AN_D1; end
            DIG_SUM:  begin value = sum;  an = AN_D2; end
            DIG_DIFF: begin value = diff; an = AN_D3; end
            default:  begin value = a;    an = AN_D0; end
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .hex (value),
        .seg (seg)
    );

endmodule

// File: tb/tb_alu_seg_top.sv
// Bench for alu_seg_top: one instance with DIVIDE_BY=1 and one with DIVIDE_BY=2
// share switches and reset. The driver pushes expected {dut, an, seg} words into
// exp_q and signals the monitor, which reads the DUT outputs and compares.
module tb_alu_seg_top;

    logic       clk;
    logic       btnC;
    logic [7:0] sw;
    logic [3:0] an1;
    logic [6:0] seg1;
    logic [3:0] an2;
    logic [6:0] seg2;

    // Entry layout: [11] = 1 selects the DIVIDE_BY=2 instance, [10:7] an, [6:0] seg.
    logic [11:0] exp_q[$];
    string       name_q[$];
    event        sample_ev;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seg_top #(.DIVIDE_BY(1)) dut1 (
        .clk  (clk),
        .btnC (btnC),
        .sw   (sw),
        .an   (an1),
        .seg  (seg1)
    );

    alu_seg_top #(.DIVIDE_BY(2)) dut2 (
        .clk  (clk),
        .btnC (btnC),
        .sw   (sw),
        .an   (an2),
        .seg  (seg2)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference tables ----------------
    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'h0: enc = 7'b1000000;
            4'h1: enc = 7'b1111001;
            4'h2: enc = 7'b0100100;
            4'h3: enc = 7'b0110000;
            4'h4: enc = 7'b0011001;
            4'h5: enc = 7'b0010010;
            4'h6: enc = 7'b0000010;
            4'h7: enc = 7'b1111000;
            4'h8: enc = 7'b0000000;
            4'h9: enc = 7'b0010000;
            4'hA: enc = 7'b0001000;
            4'hB: enc = 7'b0000011;
            4'hC: enc = 7'b1000110;
            4'hD: enc = 7'b0100001;
            4'hE: enc = 7'b0000110;
            default: enc = 7'b0001110;
        endcase
    endfunction

    function automatic logic [3:0] an_of(input int dig);
        case (dig)
            0: an_of = 4'b1110;
            1: an_of = 4'b1101;
            2: an_of = 4'b1011;
            default: an_of = 4'b0111;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic expect_out(input bit dsel, input logic [3:0] a_exp,
                              input logic [6:0] s_exp, input string nm);
        exp_q.push_back({dsel, a_exp, s_exp});
        name_q.push_back(nm);
    endtask

    task automatic sample();
        -> sample_ev;
        #0;
    endtask

    // Leaves the bench at the negedge just after the reset edge (k=0).
    task automatic do_reset();
        @(negedge clk);
        btnC = 1'b1;
        @(negedge clk);
        btnC = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Four 2-cycle slots after a reset, hand-computed values for DIVIDE_BY=1.
    task automatic slot_run(input logic [7:0] sw_val, input string tag,
                            input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
        sw = sw_val;
        do_reset();
        expect_out(1'b0, 4'b1110, s0, {tag, "_d0"}); sample(); step(2);
        expect_out(1'b0, 4'b1101, s1, {tag, "_d1"}); sample(); step(2);
        expect_out(1'b0, 4'b1011, s2, {tag, "_d2"}); sample(); step(2);
        expect_out(1'b0, 4'b0111, s3, {tag, "_d3"}); sample(); step(2);
        expect_out(1'b0, 4'b1110, s0, {tag, "_wrap"}); sample();
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [11:0] e;
        logic [10:0] act;
        string       nm;
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = e[11] ? {an2, seg2} : {an1, seg1};
                n_checks++;
                if (act !== e[10:0]) begin
                    n_fail++;
                    $display("FAIL %s: got an=%b seg=%b, expected an=%b seg=%b",
                             nm, act[10:7], act[6:0], e[10:7], e[6:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int d1_tab[10];
        int d2_tab[10];
        logic [3:0] va;
        logic [3:0] vb;
        logic [3:0] v4[4];

        d1_tab = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 1};
        d2_tab = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 2};

        btnC = 1'b0;
        sw   = 8'h00;

        // Power-up, before any clock edge.
        #2;
        expect_out(1'b0, 4'b1110, 7'b1000000, "powerup_div1");
        expect_out(1'b1, 4'b1110, 7'b1000000, "powerup_div2");
        sample();

        // Directed slot vectors.
        slot_run(8'h12, "b1_a2", 7'b0100100, 7'b1111001, 7'b0110000, 7'b1111001);
        slot_run(8'h1F, "b1_aF", 7'b0001110, 7'b1111001, 7'b1000000, 7'b0000110);
        slot_run(8'h53, "b5_a3", 7'b0110000, 7'b0010010, 7'b0000000, 7'b0000110);

        // Switch change with no clock edge: d is still 0 here.
        sw = 8'h17;
        #1;
        expect_out(1'b0, 4'b1110, 7'b1111000, "sw_comb_a7");
        sample();

        // Per-cycle phase for both dividers after reset, sw={B=1,A=2}.
        sw = 8'h12;
        do_reset();
        v4 = '{4'h2, 4'h1, 4'h3, 4'h1};
        for (int k = 0; k < 10; k++) begin
            expect_out(1'b0, an_of(d1_tab[k]), enc(v4[d1_tab[k]]), $sformatf("phase_div1_k%0d", k));
            expect_out(1'b1, an_of(d2_tab[k]), enc(v4[d2_tab[k]]), $sformatf("phase_div2_k%0d", k));
            sample();
            step(1);
        end

        // Reset while d=2 returns to digit 0 on that edge.
        do_reset();
        step(4);
        expect_out(1'b0, 4'b1011, 7'b0110000, "pre_reset_d2");
        sample();
        btnC = 1'b1;
        step(1);
        btnC = 1'b0;
        expect_out(1'b0, 4'b1110, 7'b0100100, "midscan_reset_div1");
        expect_out(1'b1, 4'b1110, 7'b0100100, "midscan_reset_div2");
        sample();

        // Exhaustive sweep: 8 cycles per pair, each pair starting at d=0 without resync.
        do_reset();
        for (int p = 0; p < 256; p++) begin
            sw = 8'(p);
            va = sw[3:0];
            vb = sw[7:4];
            #1;
            expect_out(1'b0, 4'b1110, enc(va), $sformatf("sweep_%02h_d0", p)); sample(); step(2);
            expect_out(1'b0, 4'b1101, enc(vb), $sformatf("sweep_%02h_d1", p)); sample(); step(2);
            expect_out(1'b0, 4'b1011, enc(4'(va + vb)), $sformatf("sweep_%02h_d2", p)); sample(); step(2);
            expect_out(1'b0, 4'b0111, enc(4'(va - vb)), $sformatf("sweep_%02h_d3", p)); sample(); step(2);
        end

        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
